// File: rtl/cfi_shadow_stack_pkg.sv
// Shared types and decode helpers for the commit-stage shadow-stack monitor.
// The commit-entry struct carries only the fields this monitor inspects.
package cfi_shadow_stack_pkg;

   localparam int unsigned VLEN            = 64;
   localparam int unsigned NR_COMMIT_PORTS = 2;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd1;

   typedef enum logic [3:0] {
      NONE,
      LOAD,
      STORE,
      ALU,
      CTRL_FLOW,
      MULT,
      CSR
   } fu_t;

   typedef enum logic [6:0] {
      ADD,
      SUB,
      JAL,
      JALR,
      EQ,
      NE
   } fu_op;

   typedef struct packed {
      logic valid;
   } exception_t;

   typedef struct packed {
      logic [VLEN-1:0] pc;
      fu_t             fu;
      fu_op            op;
      logic [4:0]      rs1;
      logic [4:0]      rd;
      logic            is_compressed;
      exception_t      ex;
   } scoreboard_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      AWAIT,
      VIOL
   } cfi_state_e;

   function automatic logic is_call(scoreboard_entry_t e);
      return (e.fu == CTRL_FLOW) && ((e.op == JAL) || (e.op == JALR)) && (e.rd == REG_RA);
   endfunction

   // rd == x0 excludes "jalr ra, 0(ra)", which is a call only.
   function automatic logic is_ret(scoreboard_entry_t e);
      return (e.fu == CTRL_FLOW) && (e.op == JALR) && (e.rs1 == REG_RA) && (e.rd == REG_ZERO);
   endfunction

   function automatic logic [VLEN-1:0] link_addr(scoreboard_entry_t e);
      return e.pc + (e.is_compressed ? VLEN'(2) : VLEN'(4));
   endfunction

endpackage

// File: rtl/cfi_shadow_stack_if.sv
// Commit-stage tap carrying the committing instructions and their strobes.
interface cfi_shadow_stack_if;
   import cfi_shadow_stack_pkg::*;

   scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr;
   logic              [NR_COMMIT_PORTS-1:0] commit_ack;

   modport master (output commit_instr, output commit_ack);
   modport slave  (input  commit_instr, input  commit_ack);
endinterface

// File: rtl/cfi_shadow_stack_lifo.sv
// Register-based return-address LIFO serving two ordered requests (a then b) per cycle.
// A pop on empty is ignored; a push on full overwrites the oldest entry.
module cfi_shadow_stack_lifo
   import cfi_shadow_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_a,
   input  logic                   pop_a,
   input  logic [VLEN-1:0]        data_a,
   input  logic                   push_b,
   input  logic                   pop_b,
   input  logic [VLEN-1:0]        data_b,
   output logic                   empty_a,
   output logic                   full_a,
   output logic [VLEN-1:0]        top_a,
   output logic                   empty_b,
   output logic                   full_b,
   output logic [VLEN-1:0]        top_b,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;
   localparam ptr_t PONE = ptr_t'(1);
   localparam cnt_t FULL = cnt_t'(DEPTH);

   function automatic cnt_t depth_step(cnt_t d, logic push, logic pop);
      if (pop && (d != '0))
         return d - cnt_t'(1);
      if (push && (d != FULL))
         return d + cnt_t'(1);
      return d;
   endfunction

   logic [VLEN-1:0] mem_q [DEPTH];
   ptr_t ptr_q, ptr_m, ptr_n;
   cnt_t depth_q, depth_m;
   logic overflow_q;
   logic pop_ok_a, pop_ok_b;

   assign empty_a  = (depth_q == '0);
   assign full_a   = (depth_q == FULL);
   assign top_a    = mem_q[ptr_q - PONE];
   assign pop_ok_a = pop_a && !empty_a;

   always_comb begin
      ptr_m = ptr_q;
      if (push_a)
         ptr_m = ptr_q + PONE;
      else if (pop_ok_a)
         ptr_m = ptr_q - PONE;
   end

   assign depth_m  = depth_step(depth_q, push_a, pop_a);
   assign empty_b  = (depth_m == '0);
   assign full_b   = (depth_m == FULL);
   // A pop right after a same-cycle push must see the value not yet in mem_q.
   assign top_b    = push_a ? data_a : mem_q[ptr_m - PONE];
   assign pop_ok_b = pop_b && !empty_b;

   always_comb begin
      ptr_n = ptr_m;
      if (push_b)
         ptr_n = ptr_m + PONE;
      else if (pop_ok_b)
         ptr_n = ptr_m - PONE;
   end

   // ---- stage p1: stack storage and bookkeeping ----
   always_ff @(posedge clk_i) begin
      if (push_a)
         mem_q[ptr_q] <= data_a;
      if (push_b)
         mem_q[ptr_m] <= data_b;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         depth_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         ptr_q      <= ptr_n;
         depth_q    <= depth_step(depth_m, push_b, pop_b);
         overflow_q <= overflow_q | (push_a & full_a) | (push_b & full_b);
      end
   end

   assign depth    = depth_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/cfi_shadow_stack.sv
// Commit-stage shadow stack: pushes call link addresses, and checks that the
// instruction committed after each return sits at the popped address.
module cfi_shadow_stack
   import cfi_shadow_stack_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter bit          WRAP_ON_FULL = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   cfi_shadow_stack_if.slave      commit,
   output logic                   flow_integrity_violated_o,
   output logic [$clog2(DEPTH):0] ss_depth_o,
   output logic                   ss_overflow_o,
   output logic                   ss_underflow_o
);

   scoreboard_entry_t ins_a, ins_b;
   logic              live_a, live_b;
   cfi_state_e        state_p1, state_a, state_b;
   logic [VLEN-1:0]   expected_p1, exp_a, exp_b;
   logic              underflow_p1;
   logic              push_a, pop_a, uf_a;
   logic              push_b, pop_b, uf_b;
   logic              empty_a, full_a, empty_b, full_b;
   logic [VLEN-1:0]   top_a, top_b;

   assign ins_a  = commit.commit_instr[0];
   assign ins_b  = commit.commit_instr[1];
   assign live_a = commit.commit_ack[0] && !ins_a.ex.valid;
   assign live_b = commit.commit_ack[1] && !ins_b.ex.valid;

   // Slot 0 sees the registered state; a matching target re-enters IDLE and is
   // then decoded like any other instruction.
   always_comb begin
      state_a = state_p1;
      exp_a   = expected_p1;
      push_a  = 1'b0;
      pop_a   = 1'b0;
      uf_a    = 1'b0;
      if (live_a) begin
         if (state_a == AWAIT)
            state_a = (ins_a.pc == expected_p1) ? IDLE : VIOL;
         if (state_a == IDLE) begin
            if (is_call(ins_a)) begin
               if (full_a && !WRAP_ON_FULL)
                  state_a = VIOL;
               else
                  push_a = 1'b1;
            end else if (is_ret(ins_a)) begin
               if (empty_a) begin
                  uf_a = 1'b1;
               end else begin
                  pop_a   = 1'b1;
                  exp_a   = top_a;
                  state_a = AWAIT;
               end
            end
         end
      end
   end

   // Slot 1 continues from wherever slot 0 left the FSM and the stack.
   always_comb begin
      state_b = state_a;
      exp_b   = exp_a;
      push_b  = 1'b0;
      pop_b   = 1'b0;
      uf_b    = 1'b0;
      if (live_b) begin
         if (state_b == AWAIT)
            state_b = (ins_b.pc == exp_a) ? IDLE : VIOL;
         if (state_b == IDLE) begin
            if (is_call(ins_b)) begin
               if (full_b && !WRAP_ON_FULL)
                  state_b = VIOL;
               else
                  push_b = 1'b1;
            end else if (is_ret(ins_b)) begin
               if (empty_b) begin
                  uf_b = 1'b1;
               end else begin
                  pop_b   = 1'b1;
                  exp_b   = top_b;
                  state_b = AWAIT;
               end
            end
         end
      end
   end

   cfi_shadow_stack_lifo #(
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .push_a   (push_a),
      .pop_a    (pop_a),
      .data_a   (link_addr(ins_a)),
      .push_b   (push_b),
      .pop_b    (pop_b),
      .data_b   (link_addr(ins_b)),
      .empty_a  (empty_a),
      .full_a   (full_a),
      .top_a    (top_a),
      .empty_b  (empty_b),
      .full_b   (full_b),
      .top_b    (top_b),
      .depth    (ss_depth_o),
      .overflow (ss_overflow_o)
   );

   // ---- stage p1: FSM state, pending target and underflow pulse ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_p1     <= IDLE;
         underflow_p1 <= 1'b0;
      end else begin
         state_p1     <= state_b;
         underflow_p1 <= uf_a | uf_b;
      end
   end

   always_ff @(posedge clk_i) begin
      expected_p1 <= exp_b;
   end

   assign flow_integrity_violated_o = (state_p1 == VIOL);
   assign ss_underflow_o            = underflow_p1;

endmodule
